// File: rtl/packet_ejector_pkg.sv
// Shared NoC definitions: packet geometry, field positions and ejector FSM states.
// The injector slices packets with the same field constants.
package packet_ejector_pkg;

  localparam int PACKETWIDTH = 55;

  localparam int ROUTE_MSB   = 54;
  localparam int ROUTE_LSB   = 25;
  localparam int PKTID_MSB   = 24;
  localparam int PKTID_LSB   = 15;
  localparam int SRC_MSB     = 14;
  localparam int SRC_LSB     = 9;
  localparam int PAYLOAD_MSB = 8;
  localparam int PAYLOAD_LSB = 0;

  // PacketID and SrcID are adjacent, so the duplicate key is one contiguous slice.
  localparam int DUPKEY_W = PKTID_MSB - SRC_LSB + 1;
  localparam int SRC_W    = SRC_MSB - SRC_LSB + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } ejState_t;

endpackage

// File: rtl/packet_ejector_fifo.sv
// Show-ahead receive FIFO: the head entry is always visible on rdData_o.
// The writer must never push while count_o == DEPTH; reads of an empty FIFO are ignored.
module ejector_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 55
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wrEn_i,
  input  logic [WIDTH-1:0]         wrData_i,
  input  logic                     rdEn_i,
  output logic [WIDTH-1:0]         rdData_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wrPtr_q;
  logic [PW-1:0]    rdPtr_q;
  logic [PW:0]      count_q;
  logic             doRead;

  assign doRead   = rdEn_i && (count_q != '0);
  assign rdData_o = mem_q[rdPtr_q];
  assign count_o  = count_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (wrEn_i) wrPtr_q <= wrPtr_q + 1'b1;
      if (doRead) rdPtr_q <= rdPtr_q + 1'b1;
      case ({wrEn_i, doRead})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wrEn_i) mem_q[wrPtr_q] <= wrData_i;
  end

endmodule

// File: rtl/packet_ejector.sv
// Local-port sink: grants router requests, drops back-to-back duplicates,
// buffers packets for the PE and keeps receive/duplicate/stall statistics.
module packet_ejector
  import packet_ejector_pkg::*;
#(
  parameter logic [5:0] routerID    = 6'b000_000,
  parameter int         packetwidth = PACKETWIDTH,
  parameter int         DEPTH       = 4,
  parameter int         STALL_LIMIT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ReqUpStr,
  input  logic [packetwidth-1:0] PacketIn,
  output logic                   GntUpStr,
  output logic                   UpStrFull,
  output logic                   PktValid,
  output logic [packetwidth-1:0] PktData,
  input  logic                   PktPop,
  output logic                   RxEvent,
  output logic [SRC_W-1:0]       RxSrcID,
  output logic [15:0]            RxCount,
  output logic [7:0]             DupCount,
  output logic                   StallFlag
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STALL_LIMIT + 1);

  ejState_t            state_q;
  logic                gnt_q;
  logic                rxEvent_q;
  logic [SRC_W-1:0]    rxSrc_q;
  logic [15:0]         rxCount_q;
  logic [7:0]          dupCount_q;
  logic [SW-1:0]       stallCnt_q;
  logic [DUPKEY_W-1:0] lastKey_q;
  logic                lastValid_q;

  logic [CW-1:0]       fifoCount;
  logic                full;
  logic                accept;
  logic                isDup;
  logic                fifoWr;

  // Full uses the pre-edge count only; a same-edge pop never lets a request through.
  assign full   = (fifoCount == CW'(DEPTH));
  assign accept = (state_q == ST_IDLE) && ReqUpStr && !full;
  assign isDup  = lastValid_q && (PacketIn[PKTID_MSB:SRC_LSB] == lastKey_q);
  assign fifoWr = accept && !isDup;

  ejector_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (packetwidth)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wrEn_i   (fifoWr),
    .wrData_i (PacketIn),
    .rdEn_i   (PktPop),
    .rdData_o (PktData),
    .count_o  (fifoCount)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 1'b0;
      rxEvent_q   <= 1'b0;
      rxSrc_q     <= '0;
      rxCount_q   <= '0;
      dupCount_q  <= '0;
      stallCnt_q  <= '0;
      lastKey_q   <= '0;
      lastValid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            gnt_q      <= 1'b1;
            stallCnt_q <= '0;
            state_q    <= ST_GRANT;
            if (isDup) begin
              if (dupCount_q != 8'hFF) dupCount_q <= dupCount_q + 8'd1;
            end else begin
              rxEvent_q   <= 1'b1;
              rxSrc_q     <= PacketIn[SRC_MSB:SRC_LSB];
              rxCount_q   <= rxCount_q + 16'd1;
              lastKey_q   <= PacketIn[PKTID_MSB:SRC_LSB];
              lastValid_q <= 1'b1;
            end
          end else if (ReqUpStr && (stallCnt_q != SW'(STALL_LIMIT))) begin
            stallCnt_q <= stallCnt_q + 1'b1;
          end
        end
        ST_GRANT: begin
          gnt_q     <= 1'b0;
          rxEvent_q <= 1'b0;
          state_q   <= ST_RELEASE;
        end
        // Waiting for Req to drop keeps a held request from being captured twice.
        ST_RELEASE: begin
          if (!ReqUpStr) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign GntUpStr  = gnt_q;
  assign RxEvent   = rxEvent_q;
  assign RxSrcID   = rxSrc_q;
  assign RxCount   = rxCount_q;
  assign DupCount  = dupCount_q;
  assign StallFlag = (stallCnt_q == SW'(STALL_LIMIT));
  assign UpStrFull = full;
  assign PktValid  = (fifoCount != '0);

endmodule

// File: tb/tb_packet_ejector.sv
// Scoreboard bench for packet_ejector: an injector-style driver feeds a
// queue-based reference model, and a PE-side monitor pops and compares.
module tb_packet_ejector;
  import packet_ejector_pkg::*;

  localparam int DEPTH       = 4;
  localparam int STALL_LIMIT = 16;
  localparam int PW          = PACKETWIDTH;

  logic          clk;
  logic          reset;
  logic          ReqUpStr;
  logic [PW-1:0] PacketIn;
  logic          GntUpStr;
  logic          UpStrFull;
  logic          PktValid;
  logic [PW-1:0] PktData;
  logic          PktPop;
  logic          RxEvent;
  logic [5:0]    RxSrcID;
  logic [15:0]   RxCount;
  logic [7:0]    DupCount;
  logic          StallFlag;

  packet_ejector #(
    .routerID    (6'b000_000),
    .packetwidth (PW),
    .DEPTH       (DEPTH),
    .STALL_LIMIT (STALL_LIMIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ReqUpStr  (ReqUpStr),
    .PacketIn  (PacketIn),
    .GntUpStr  (GntUpStr),
    .UpStrFull (UpStrFull),
    .PktValid  (PktValid),
    .PktData   (PktData),
    .PktPop    (PktPop),
    .RxEvent   (RxEvent),
    .RxSrcID   (RxSrcID),
    .RxCount   (RxCount),
    .DupCount  (DupCount),
    .StallFlag (StallFlag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: contents the PE should see, plus the expected statistics.
  logic [PW-1:0] expQ[$];
  logic [15:0]   expKey;
  bit            expKeyValid;
  logic [15:0]   expRx;
  logic [7:0]    expDup;
  logic [5:0]    expSrc;
  int            stallRun;

  int nChecks;
  int nFails;
  int popMode;
  bit popOnce;
  bit inReset;

  function automatic void checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [PW-1:0] mkPkt(input logic [29:0] route, input logic [9:0] id,
                                         input logic [5:0] src, input logic [8:0] pay);
    return {route, id, src, pay};
  endfunction

  function automatic void modelReset();
    expQ.delete();
    expKey      = '0;
    expKeyValid = 1'b0;
    expRx       = '0;
    expDup      = '0;
    expSrc      = '0;
    stallRun    = 0;
  endfunction

  // A granted packet is a duplicate only if its {PacketID,SrcID} matches the last written one.
  function automatic bit modelAccept(input logic [PW-1:0] pkt);
    logic [15:0] key;
    key      = pkt[PKTID_MSB:SRC_LSB];
    stallRun = 0;
    if (expKeyValid && key == expKey) begin
      if (expDup != 8'hFF) expDup++;
      return 1'b1;
    end
    expQ.push_back(pkt);
    expRx++;
    expSrc      = pkt[SRC_MSB:SRC_LSB];
    expKey      = key;
    expKeyValid = 1'b1;
    return 1'b0;
  endfunction

  // Injector behaviour: raise Req, wait for Gnt, optionally hold Req, then drop it.
  // Must be called on a negedge, before the monitor's #1 slot.
  task automatic applyStimulus(input logic [PW-1:0] pkt, input int holdCycles,
                               input bit resetAtGrant, input int maxWait);
    bit expGnt;
    bit dup;
    bit granted;
    int waited;
    granted  = 1'b0;
    waited   = 0;
    PacketIn = pkt;
    ReqUpStr = 1'b1;
    while (!granted && waited < maxWait) begin
      expGnt = (expQ.size() < DEPTH);
      @(posedge clk);
      @(negedge clk);
      checkOutput("gntUpStr", GntUpStr, expGnt);
      if (expGnt) begin
        granted = 1'b1;
        dup     = modelAccept(pkt);
        checkOutput("rxEvent", RxEvent, !dup);
        checkOutput("rxSrcID", RxSrcID, expSrc);
        checkOutput("rxCount", RxCount, expRx);
        checkOutput("dupCount", DupCount, expDup);
        checkOutput("stallFlagCleared", StallFlag, 0);
      end else begin
        waited++;
        if (stallRun < STALL_LIMIT) stallRun++;
        checkOutput("stallFlag", StallFlag, stallRun == STALL_LIMIT);
      end
    end
    if (!granted) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL gntTimeout: got no grant after %0d cycles, expected one within %0d", waited, maxWait);
      ReqUpStr = 1'b0;
      return;
    end
    if (resetAtGrant) begin
      inReset  = 1'b1;
      reset    = 1'b0;
      ReqUpStr = 1'b0;
      #1;
      checkOutput("resetGnt", GntUpStr, 0);
      checkOutput("resetPktValid", PktValid, 0);
      checkOutput("resetRxEvent", RxEvent, 0);
      checkOutput("resetRxCount", RxCount, 0);
      checkOutput("resetDupCount", DupCount, 0);
      checkOutput("resetRxSrcID", RxSrcID, 0);
      modelReset();
      @(negedge clk);
      reset   = 1'b1;
      inReset = 1'b0;
      @(negedge clk);
      return;
    end
    repeat (holdCycles) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("heldReqNoGnt", GntUpStr, 0);
      checkOutput("heldReqNoEvent", RxEvent, 0);
    end
    ReqUpStr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("gntPulseEnd", GntUpStr, 0);
    checkOutput("rxEventPulseEnd", RxEvent, 0);
    checkOutput("rxCountStable", RxCount, expRx);
    @(posedge clk);
    @(negedge clk);
  endtask

  // PE side: decides pops and compares the head against the model whenever it consumes.
  initial begin
    bit doPop;
    bit expValid;
    PktPop = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (inReset) begin
        PktPop = 1'b0;
      end else begin
        expValid = (expQ.size() != 0);
        checkOutput("pktValid", PktValid, expValid);
        checkOutput("upStrFull", UpStrFull, expQ.size() == DEPTH);
        doPop = expValid && (popMode == 2 || popOnce || (popMode == 1 && $urandom_range(1) == 1));
        if (doPop) begin
          checkOutput("pktData", PktData, expQ[0]);
          void'(expQ.pop_front());
          popOnce = 1'b0;
        end
        PktPop = doPop;
      end
    end
  end

  initial begin
    logic [PW-1:0] p;
    logic [PW-1:0] prev;
    nChecks  = 0;
    nFails   = 0;
    popMode  = 0;
    popOnce  = 1'b0;
    inReset  = 1'b1;
    ReqUpStr = 1'b0;
    PacketIn = '0;
    modelReset();
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rstGnt", GntUpStr, 0);
    checkOutput("rstPktValid", PktValid, 0);
    checkOutput("rstUpStrFull", UpStrFull, 0);
    checkOutput("rstRxEvent", RxEvent, 0);
    checkOutput("rstRxSrcID", RxSrcID, 0);
    checkOutput("rstRxCount", RxCount, 0);
    checkOutput("rstDupCount", DupCount, 0);
    checkOutput("rstStallFlag", StallFlag, 0);
    reset   = 1'b1;
    inReset = 1'b0;
    @(negedge clk);

    $display("[TB] single packet and duplicate");
    p = mkPkt(30'h1, 10'd5, 6'b001_001, 9'h0AB);
    applyStimulus(p, 0, 1'b0, 20);
    checkOutput("singlePktData", PktData, p);
    checkOutput("singlePktValid", PktValid, 1);
    applyStimulus(p, 0, 1'b0, 20);
    checkOutput("dupRxCount", RxCount, 1);
    checkOutput("dupDupCount", DupCount, 1);
    popMode = 2;
    repeat (4) @(negedge clk);
    popMode = 0;

    $display("[TB] fill, stall and release by one pop");
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(mkPkt(30'h100 + 30'(i), 10'd20 + 10'(i), 6'd3, 9'(i)), 0, 1'b0, 20);
    checkOutput("fillFull", UpStrFull, 1);
    fork
      applyStimulus(mkPkt(30'h2AA, 10'd99, 6'd4, 9'h155), 0, 1'b0, 60);
      begin
        repeat (20) @(negedge clk);
        popOnce = 1'b1;
      end
    join
    popMode = 2;
    repeat (6) @(negedge clk);
    popMode = 0;

    $display("[TB] simultaneous write and pop");
    applyStimulus(mkPkt(30'h3, 10'd40, 6'd7, 9'h011), 0, 1'b0, 20);
    applyStimulus(mkPkt(30'h4, 10'd41, 6'd7, 9'h022), 0, 1'b0, 20);
    popOnce = 1'b1;
    applyStimulus(mkPkt(30'h5, 10'd42, 6'd8, 9'h033), 0, 1'b0, 20);
    checkOutput("simulFull", UpStrFull, 0);
    popMode = 2;
    repeat (4) @(negedge clk);
    popMode = 0;

    $display("[TB] sticky request");
    applyStimulus(mkPkt(30'h6, 10'd50, 6'd9, 9'h044), 10, 1'b0, 20);

    $display("[TB] duplicate counter saturation");
    p = mkPkt(30'h7, 10'd60, 6'd10, 9'h055);
    popMode = 1;
    for (int i = 0; i < 258; i++) applyStimulus(p, 0, 1'b0, 20);
    checkOutput("dupSaturated", DupCount, 8'hFF);

    $display("[TB] randomized traffic");
    prev = p;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(3) == 0)
        p = {30'($urandom), prev[PKTID_MSB:SRC_LSB], 9'($urandom)};
      else
        p = mkPkt(30'($urandom), 10'($urandom_range(3)), 6'($urandom_range(1)), 9'($urandom));
      applyStimulus(p, $urandom_range(2), 1'b0, 200);
      prev = p;
    end

    $display("[TB] reset during grant");
    popMode = 0;
    applyStimulus(mkPkt(30'h8, 10'd70, 6'd11, 9'h066), 0, 1'b0, 200);
    applyStimulus(mkPkt(30'h9, 10'd71, 6'd12, 9'h077), 0, 1'b1, 200);
    p = mkPkt(30'hA, 10'd72, 6'd13, 9'h088);
    applyStimulus(p, 0, 1'b0, 20);
    checkOutput("postResetRxCount", RxCount, 1);
    checkOutput("postResetPktData", PktData, p);

    popMode = 2;
    repeat (8) @(negedge clk);
    checkOutput("drainedValid", PktValid, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
